// File: rtl/adder_op_sequencer_if.sv
// Bundles the button/switch inputs and the display-facing results of the
// add/sub operand sequencer. The bench drives through master; the block uses slave.
interface adder_op_sequencer_if;
    logic       btn_next;
    logic       btn_clear;
    logic       sub;
    logic [3:0] sw;
    logic [3:0] ip1;
    logic [3:0] ip2;
    logic [3:0] sum;
    logic       carry_out;
    logic       overflow;
    logic       valid;
    logic [1:0] state;

    modport master (
        output btn_next, btn_clear, sub, sw,
        input  ip1, ip2, sum, carry_out, overflow, valid, state
    );

    modport slave (
        input  btn_next, btn_clear, sub, sw,
        output ip1, ip2, sum, carry_out, overflow, valid, state
    );
endinterface

// File: rtl/adder_op_sequencer.sv
// Operand entry sequencer for the 4-bit signed add/subtract lab datapath.
// Each push-button is synchronised, debounced and turned into a one-cycle
// press pulse. Operand A and then operand B are latched from the switches,
// one registered add/sub is performed, and the result is held for display.
module adder_op_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_op_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the "next" button, index 1 the "clear" button.
    logic [1:0]  raw_btn;
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  stable_q;
    logic [1:0]  stable_dly_q;
    logic [1:0]  press_q;
    logic [23:0] cnt_q [2];

    logic        next_press;
    logic        clear_press;

    state_t      state_q, state_d;
    logic [3:0]  ip1_q, ip1_d;
    logic [3:0]  ip2_q, ip2_d;
    logic [3:0]  sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        valid_q, valid_d;
    logic [5:0]  calc_res;

    // Returns {overflow, carry_out, sum[3:0]}. Subtraction is A + ~B + 1 in
    // 5-bit unsigned arithmetic; overflow compares signs against the
    // effective B operand actually fed to the adder.
    function automatic logic [5:0] add_sub(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       sub_op);
        logic [3:0] b_eff;
        logic [4:0] r;
        b_eff = sub_op ? ~b : b;
        r     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub_op};
        return {(a[3] == b_eff[3]) && (r[3] != a[3]), r};
    endfunction

    assign raw_btn     = {bus.btn_clear, bus.btn_next};
    assign next_press  = press_q[0];
    assign clear_press = press_q[1];
    assign calc_res    = add_sub(ip1_q, ip2_q, bus.sub);

    // Synchronise, debounce and edge-detect both buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= raw_btn;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            // Only a press (0->1 of the accepted level) makes a pulse.
            press_q      <= stable_q & ~stable_dly_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 24'd1;
                end
            end
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            ip1_q   <= '0;
            ip2_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ip1_q   <= ip1_d;
            ip2_q   <= ip2_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and register updates; clear beats next in every state.
    always_comb begin
        state_d = state_q;
        ip1_d   = ip1_q;
        ip2_d   = ip2_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        if (clear_press) begin
            state_d = S_A;
            ip1_d   = '0;
            ip2_d   = '0;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (next_press) begin
                        ip1_d   = bus.sw;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (next_press) begin
                        ip2_d   = bus.sw;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    sum_d   = calc_res[3:0];
                    carry_d = calc_res[4];
                    ovf_d   = calc_res[5];
                    valid_d = 1'b1;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    // Results stay on display; only valid drops on advance.
                    if (next_press) begin
                        valid_d = 1'b0;
                        state_d = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign bus.ip1       = ip1_q;
    assign bus.ip2       = ip2_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.valid     = valid_q;
    assign bus.state     = state_q;

endmodule

// File: doc/adder_op_sequencer.md
Name: adder_op_sequencer

Overview:
Sequences operand entry and evaluation for the 4-bit signed add/subtract lab datapath. Two raw push-buttons and four switches drive it. Each button is synchronised and debounced. Operand A, then operand B, is latched from the switches. One registered add/sub is performed. The block then presents ip1, ip2, sum, carry_out and overflow to the seven-segment display controller until the user advances or clears.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required before a button level is accepted (10 ms at 100 MHz); legal range 2..2^24-1.

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
btn_next  input  1  raw, bouncy "advance" button, active-high
btn_clear  input  1  raw, bouncy "clear" button, active-high
sub  input  1  switch: 0 = add, 1 = subtract (A - B)
sw  input  4  operand switches, two's complement
ip1  output  4  latched operand A
ip2  output  4  latched operand B
sum  output  4  result bits [3:0]
carry_out  output  1  bit 4 of the unsigned result
overflow  output  1  signed overflow flag
valid  output  1  high while sum/carry_out/overflow hold a current result
state  output  2  FSM state code: 0 S_A, 1 S_B, 2 S_CALC, 3 S_SHOW

Behaviour:
- Reset (rst_n low, asynchronous):
  - ip1, ip2, sum, carry_out, overflow, valid = 0; state = S_A.
  - Synchroniser flops, debounce stable levels, debounce counters and press pulses = 0.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter, 24 bits:
    - Cycle where sync == stable: counter <= 0.
    - Cycle where sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
    - Otherwise counter increments.
  - Press pulse: registered, exactly 1 cycle, on a 0->1 transition of stable. Releases produce no pulse.
  - Latency: raw edge to press pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - Any raw glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- FSM (all registered; clear_press has priority over next_press in every state):
  - S_A:
    - next_press: ip1 <= sw; -> S_B.
    - clear_press: stay in S_A.
  - S_B:
    - next_press: ip2 <= sw; -> S_CALC.
  - S_CALC (exactly one cycle, ignores presses except clear):
    - sub sampled this cycle.
    - {carry_out, sum} <= ip1 + (sub ? ~ip2 : ip2) + sub, computed 5 bits wide and unsigned.
    - overflow <= (a3 == b3') && (s3 != a3), where b3' is bit 3 of the effective B operand (~ip2 when subtracting).
    - valid <= 1; -> S_SHOW.
  - S_SHOW:
    - Outputs held.
    - next_press: valid <= 0; -> S_A. ip1/ip2/sum/flags retain their values until overwritten.
    - Switch or sub changes in S_SHOW do not alter outputs.
  - clear_press in any state:
    - -> S_A.
    - ip1, ip2, sum, carry_out, overflow, valid <= 0 on the same edge.
- Simultaneous next_press and clear_press on one cycle: clear wins; no operand latch occurs.
- A held button produces one press only; no auto-repeat.
- sw is sampled only on the next_press edge; sw changes at other times have no effect.
- Reset mid-sequence (any state, including S_CALC) returns to reset values immediately and asynchronously. Release is synchronous to the next clk edge; there is no glitch on outputs.

Test Plan:
(DEBOUNCE_CYCLES = 4 on the bench.)
- Reset then idle: rst_n low 3 cycles, release -> state = 0; all outputs 0; no press pulses for 50 cycles.
- Add with overflow: sub=0; sw=0111, clean next press; sw=0001, next press -> ip1=0111, ip2=0001; one cycle in S_CALC, then sum=1000, carry_out=0, overflow=1, valid=1, state=3.
- Subtract: sub=1, A=0011, B=0101 -> sum=1110, carry_out=0, overflow=0. Repeat with A=0101, B=0011 -> sum=0010, carry_out=1, overflow=0. Repeat with A=1000, B=0001 -> sum=0111, carry_out=1, overflow=1.
- Bounce rejection: btn_next toggles 1/0 every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one press pulse, 7 cycles after the final stable rise; state advances by one only.
- Clear priority: in S_B, both buttons rise on the same cycle with identical timing -> state = 0, ip1 = 0, ip2 unchanged at 0, valid = 0.
- Async reset mid-operation: rst_n dropped between clock edges while in S_SHOW with valid=1 -> all outputs 0 before the next clk edge; state = 0 after release.
